// File: rtl/pipeline_pkg.sv
// Shared types for the EX->memory request path.
//   MEM_SZ_*   : access size encodings carried on req_sz
//   mem_req_t  : latched request (address, store data, size, sign-extend, r/w/io)
//   mem_state_e: responder FSM states
//   size_mask  : byte mask of an access at lane offset 0
package pipeline_pkg;

  localparam logic [1:0] MEM_SZ_B = 2'd0;
  localparam logic [1:0] MEM_SZ_H = 2'd1;
  localparam logic [1:0] MEM_SZ_W = 2'd2;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  sz;
    logic        sx;
    logic        r;
    logic        w;
    logic        io;
  } mem_req_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACC0,
    ST_ACC1,
    ST_DATA,
    ST_IO_WAIT
  } mem_state_e;

  // Size 3 is illegal and handled as a word.
  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      MEM_SZ_B: size_mask = 4'b0001;
      MEM_SZ_H: size_mask = 4'b0011;
      default:  size_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering for the memory responder.
//   sz, off, wdata -> be0/be1 (byte enables of first/second word), misaligned,
//                     wdata_rot (store data rotated onto its byte lanes)
//   rd_off, rd_lo, rd_hi, sz, sx -> rd_data (load bytes extracted from the
//                     {rd_hi, rd_lo} word pair, truncated and extended)
module mem_lane_align
  import pipeline_pkg::*;
(
  input  logic [1:0]  sz,
  input  logic        sx,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  output logic [31:0] wdata_rot,
  output logic [3:0]  be0,
  output logic [3:0]  be1,
  output logic        misaligned,
  input  logic [1:0]  rd_off,
  input  logic [31:0] rd_lo,
  input  logic [31:0] rd_hi,
  output logic [31:0] rd_data
);

  logic [7:0]  be_span;
  logic [31:0] rd_raw;

  always_comb begin
    // Byte mask shifted across an 8-lane window: the upper nibble is what
    // spills into the next word.
    be_span    = {4'b0000, size_mask(sz)} << off;
    be0        = be_span[3:0];
    be1        = be_span[7:4];
    misaligned = |be_span[7:4];

    // Rotate left by 8*off, expressed as a right shift of the doubled word
    // so off = 0 needs no special case.
    wdata_rot  = 32'({wdata, wdata} >> (6'd32 - {1'b0, off, 3'b000}));

    rd_raw     = 32'({rd_hi, rd_lo} >> {rd_off, 3'b000});
    case (sz)
      MEM_SZ_B: rd_data = {{24{sx & rd_raw[7]}},  rd_raw[7:0]};
      MEM_SZ_H: rd_data = {{16{sx & rd_raw[15]}}, rd_raw[15:0]};
      default:  rd_data = rd_raw;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Responder end of the EX->memory request interface.
//   req_*      : one load/store/IO request, accepted when req_ready (IDLE)
//   resp_*     : registered one-cycle completion pulse, extended load data, IO error
//   sram_*     : 1-cycle-latency single-port data SRAM with byte enables;
//                misaligned accesses take two word accesses
//   io_*       : ack-based IO port, request held until io_ack or timeout
module mem_responder
  import pipeline_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned IO_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_sz,
  input  logic              req_sx,
  input  logic              req_r,
  input  logic              req_w,
  input  logic              req_io,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              sram_en,
  output logic [3:0]        sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata,
  output logic              io_req,
  output logic              io_we,
  output logic [15:0]       io_addr,
  output logic [31:0]       io_wdata,
  input  logic              io_ack,
  input  logic [31:0]       io_rdata
);

  localparam int unsigned CNT_W = $clog2(IO_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IO_TIMEOUT - 1);

  mem_state_e        state_q, state_d;
  mem_req_t          req_q;
  logic [31:0]       w0_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              resp_valid_q, resp_err_q;
  logic [31:0]       resp_rdata_q;

  logic              accept;
  logic              resp_fire, resp_err_d;
  logic [31:0]       resp_data_d;
  logic              sram_en_c, io_req_c;
  logic [3:0]        sram_we_c;
  logic [ADDR_W-1:0] word_addr;

  logic [3:0]        be0, be1;
  logic              misaligned;
  logic [31:0]       wdata_rot, rd_data;
  logic [1:0]        rd_off;
  logic [31:0]       rd_lo, rd_hi;

  logic              unused_bits;
  assign unused_bits = ^{req_q.addr[31:16], req_q.r};

  assign word_addr = req_q.addr[ADDR_W+1:2];

  mem_lane_align u_align (
    .sz         (req_q.sz),
    .sx         (req_q.sx),
    .off        (req_q.addr[1:0]),
    .wdata      (req_q.wdata),
    .wdata_rot  (wdata_rot),
    .be0        (be0),
    .be1        (be1),
    .misaligned (misaligned),
    .rd_off     (rd_off),
    .rd_lo      (rd_lo),
    .rd_hi      (rd_hi),
    .rd_data    (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      req_q        <= '0;
      w0_q         <= '0;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_fire;
      if (accept) begin
        req_q <= '{addr: req_addr, wdata: req_wdata, sz: req_sz, sx: req_sx,
                   r: req_r, w: req_w, io: req_io};
      end
      // During ACC1 the SRAM is returning the word addressed in ACC0.
      if (state_q == ST_ACC1) begin
        w0_q <= sram_rdata;
      end
      if (state_q == ST_IO_WAIT && state_d == ST_IO_WAIT) begin
        cnt_q <= cnt_q + 1'b1;
      end else begin
        cnt_q <= '0;
      end
      if (resp_fire) begin
        resp_rdata_q <= resp_data_d;
        resp_err_q   <= resp_err_d;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    resp_fire   = 1'b0;
    resp_err_d  = 1'b0;
    resp_data_d = '0;
    sram_en_c   = 1'b0;
    sram_we_c   = '0;
    sram_addr   = word_addr;
    io_req_c    = 1'b0;
    rd_off      = req_q.addr[1:0];
    rd_lo       = sram_rdata;
    rd_hi       = sram_rdata;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && (req_r || req_w)) begin
          accept  = 1'b1;
          state_d = req_io ? ST_IO_WAIT : ST_ACC0;
        end
      end
      ST_ACC0: begin
        sram_en_c = 1'b1;
        sram_we_c = req_q.w ? be0 : 4'b0000;
        state_d   = misaligned ? ST_ACC1 : ST_DATA;
      end
      ST_ACC1: begin
        sram_en_c = 1'b1;
        sram_addr = word_addr + 1'b1;
        sram_we_c = req_q.w ? be1 : 4'b0000;
        state_d   = ST_DATA;
      end
      ST_DATA: begin
        rd_lo       = misaligned ? w0_q : sram_rdata;
        resp_fire   = 1'b1;
        resp_data_d = req_q.w ? '0 : rd_data;
        state_d     = ST_IDLE;
      end
      ST_IO_WAIT: begin
        io_req_c = 1'b1;
        // IO data arrives right-justified; only size/sign handling applies.
        rd_off   = 2'b00;
        rd_lo    = io_rdata;
        rd_hi    = '0;
        if (io_ack) begin
          resp_fire   = 1'b1;
          resp_data_d = req_q.w ? '0 : rd_data;
          state_d     = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          resp_fire  = 1'b1;
          resp_err_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset gates the strobes so an access in flight at reset never reaches
  // the SRAM or IO port on the reset edge.
  assign sram_en    = sram_en_c & ~rst;
  assign sram_we    = sram_we_c & {4{~rst}};
  assign sram_wdata = wdata_rot;
  assign io_req     = io_req_c & ~rst;
  assign io_we      = io_req & req_q.w;
  assign io_addr    = req_q.addr[15:0];
  assign io_wdata   = req_q.wdata;

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_sz;
  logic        req_sx, req_r, req_w, req_io;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [9:0]  sram_addr;
  logic [31:0] sram_wdata, sram_rdata;
  logic        io_req, io_we, io_ack;
  logic [15:0] io_addr;
  logic [31:0] io_wdata, io_rdata;

  int nvec = 0;
  int nerr = 0;

  logic [31:0] mem [0:1023];

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(10), .IO_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_sz(req_sz), .req_sx(req_sx), .req_r(req_r),
    .req_w(req_w), .req_io(req_io),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_ack(io_ack), .io_rdata(io_rdata)
  );

  // Behavioural 1-cycle-latency SRAM with byte enables.
  always @(posedge clk) begin
    if (sram_en) begin
      for (int b = 0; b < 4; b++)
        if (sram_we[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      sram_rdata <= mem[sram_addr];
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents one request for a single edge; returns 1 time unit after it.
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                       input logic sx, input logic r, input logic w, input logic io);
    req_valid = 1'b1; req_addr = a; req_wdata = d; req_sz = sz;
    req_sx = sx; req_r = r; req_w = w; req_io = io;
    @(posedge clk); #1;
    req_valid = 1'b0; req_r = 1'b0; req_w = 1'b0; req_io = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    nvec++; if (req_ready !== 1'b1) begin nerr++; $display("FAIL rst_ready: got %b want 1", req_ready); end
    nvec++; if (resp_valid !== 1'b0) begin nerr++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
    nvec++; if (resp_err !== 1'b0) begin nerr++; $display("FAIL rst_resp_err: got %b want 0", resp_err); end
    nvec++; if (resp_rdata !== 32'h0) begin nerr++; $display("FAIL rst_rdata: got %h want 0", resp_rdata); end
    nvec++; if ({sram_en, sram_we} !== 5'b0) begin nerr++; $display("FAIL rst_sram: got %b want 0", {sram_en, sram_we}); end
    nvec++; if ({io_req, io_we} !== 2'b0) begin nerr++; $display("FAIL rst_io: got %b want 0", {io_req, io_we}); end
  endtask

  task automatic test_aligned_word;
    issue(32'h100, 32'hDEADBEEF, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    nvec++; if ({sram_en, sram_we} !== 5'b1_1111) begin nerr++; $display("FAIL sw_we: got %b want 11111", {sram_en, sram_we}); end
    nvec++; if (sram_addr !== 10'h040) begin nerr++; $display("FAIL sw_addr: got %h want 040", sram_addr); end
    nvec++; if (sram_wdata !== 32'hDEADBEEF) begin nerr++; $display("FAIL sw_wdata: got %h want deadbeef", sram_wdata); end
    nvec++; if (req_ready !== 1'b0) begin nerr++; $display("FAIL sw_busy: got %b want 0", req_ready); end
    step(1);
    nvec++; if (resp_valid !== 1'b0) begin nerr++; $display("FAIL sw_early: got %b want 0", resp_valid); end
    step(1);
    nvec++; if (resp_valid !== 1'b1) begin nerr++; $display("FAIL sw_resp: got %b want 1", resp_valid); end
    nvec++; if (resp_rdata !== 32'h0) begin nerr++; $display("FAIL sw_rdata: got %h want 0", resp_rdata); end
    // Back-to-back: next request issued in the response cycle.
    issue(32'h100, 32'h0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    nvec++; if (resp_valid !== 1'b0) begin nerr++; $display("FAIL resp_pulse: got %b want 0", resp_valid); end
    nvec++; if ({sram_en, sram_we} !== 5'b1_0000) begin nerr++; $display("FAIL lw_we: got %b want 10000", {sram_en, sram_we}); end
    step(2);
    nvec++; if (resp_valid !== 1'b1) begin nerr++; $display("FAIL lw_resp: got %b want 1", resp_valid); end
    nvec++; if (resp_rdata !== 32'hDEADBEEF) begin nerr++; $display("FAIL lw_rdata: got %h want deadbeef", resp_rdata); end
    step(1);
    nvec++; if (resp_rdata !== 32'hDEADBEEF) begin nerr++; $display("FAIL rdata_hold: got %h want deadbeef", resp_rdata); end
  endtask

  task automatic test_byte_half;
    issue(32'h103, 32'h80808080, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    nvec++; if (sram_we !== 4'b1000) begin nerr++; $display("FAIL sb_we: got %b want 1000", sram_we); end
    step(2);
    issue(32'h103, 32'h0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(2);
    nvec++; if (resp_rdata !== 32'hFFFFFF80) begin nerr++; $display("FAIL lb: got %h want ffffff80", resp_rdata); end
    issue(32'h103, 32'h0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(2);
    nvec++; if (resp_rdata !== 32'h00000080) begin nerr++; $display("FAIL lbu: got %h want 00000080", resp_rdata); end
    issue(32'h102, 32'h0, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(2);
    nvec++; if (resp_rdata !== 32'hFFFF80AD) begin nerr++; $display("FAIL lh: got %h want ffff80ad", resp_rdata); end
  endtask

  task automatic test_misaligned;
    issue(32'h1FE, 32'h11223344, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    nvec++; if ({sram_we, sram_addr} !== {4'b1100, 10'h07F}) begin nerr++; $display("FAIL mis_acc0: got %b/%h want 1100/07f", sram_we, sram_addr); end
    nvec++; if (sram_wdata !== 32'h33441122) begin nerr++; $display("FAIL mis_wdata: got %h want 33441122", sram_wdata); end
    step(1);
    nvec++; if ({sram_en, sram_we, sram_addr} !== {1'b1, 4'b0011, 10'h080}) begin nerr++; $display("FAIL mis_acc1: got %b/%h want 0011/080", sram_we, sram_addr); end
    step(1);
    nvec++; if (resp_valid !== 1'b0) begin nerr++; $display("FAIL mis_early: got %b want 0", resp_valid); end
    step(1);
    nvec++; if (resp_valid !== 1'b1) begin nerr++; $display("FAIL mis_sw_resp: got %b want 1", resp_valid); end
    issue(32'h1FE, 32'h0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    step(2);
    nvec++; if (resp_valid !== 1'b0) begin nerr++; $display("FAIL mis_lw_early: got %b want 0", resp_valid); end
    step(1);
    nvec++; if (resp_rdata !== 32'h11223344) begin nerr++; $display("FAIL mis_lw: got %h want 11223344", resp_rdata); end
  endtask

  task automatic test_wrap;
    issue(32'hFFE, 32'hCAFEF00D, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    nvec++; if (sram_addr !== 10'h3FF) begin nerr++; $display("FAIL wrap_acc0: got %h want 3ff", sram_addr); end
    step(1);
    nvec++; if ({sram_we, sram_addr} !== {4'b0011, 10'h000}) begin nerr++; $display("FAIL wrap_acc1: got %b/%h want 0011/000", sram_we, sram_addr); end
    step(2);
    issue(32'hFFE, 32'h0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    step(3);
    nvec++; if (resp_rdata !== 32'hCAFEF00D) begin nerr++; $display("FAIL wrap_lw: got %h want cafef00d", resp_rdata); end
  endtask

  task automatic test_ignored;
    io_ack = 1'b1;
    issue(32'h40, 32'h0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    nvec++; if ({req_ready, sram_en, io_req} !== 3'b100) begin nerr++; $display("FAIL ign_state: got %b want 100", {req_ready, sram_en, io_req}); end
    step(2);
    io_ack = 1'b0;
    nvec++; if (resp_valid !== 1'b0) begin nerr++; $display("FAIL ign_resp: got %b want 0", resp_valid); end
  endtask

  task automatic test_io;
    issue(32'h00051234, 32'h0, 2'd1, 1'b1, 1'b1, 1'b0, 1'b1);
    nvec++; if ({io_req, io_we, io_addr} !== {2'b10, 16'h1234}) begin nerr++; $display("FAIL io_rd_req: got %b%b/%h want 10/1234", io_req, io_we, io_addr); end
    nvec++; if (sram_en !== 1'b0) begin nerr++; $display("FAIL io_no_sram: got %b want 0", sram_en); end
    step(4);
    nvec++; if ({io_req, resp_valid} !== 2'b10) begin nerr++; $display("FAIL io_wait: got %b want 10", {io_req, resp_valid}); end
    io_ack = 1'b1; io_rdata = 32'h0000ABCD;
    step(1);
    io_ack = 1'b0; io_rdata = 32'h0;
    nvec++; if ({resp_valid, resp_err, io_req} !== 3'b100) begin nerr++; $display("FAIL io_rd_resp: got %b want 100", {resp_valid, resp_err, io_req}); end
    nvec++; if (resp_rdata !== 32'hFFFFABCD) begin nerr++; $display("FAIL io_rd_data: got %h want ffffabcd", resp_rdata); end
    issue(32'h0000BEEF, 32'hA5A5A5A5, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1);
    nvec++; if ({io_req, io_we, io_addr, io_wdata} !== {2'b11, 16'hBEEF, 32'hA5A5A5A5}) begin nerr++; $display("FAIL io_wr_req: got %b%b/%h/%h want 11/beef/a5a5a5a5", io_req, io_we, io_addr, io_wdata); end
    io_ack = 1'b1;
    step(1);
    io_ack = 1'b0;
    nvec++; if ({resp_valid, resp_rdata} !== {1'b1, 32'h0}) begin nerr++; $display("FAIL io_wr_resp: got %b/%h want 1/0", resp_valid, resp_rdata); end
  endtask

  task automatic test_io_timeout;
    int n;
    issue(32'h0000C000, 32'h0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b1);
    n = 0;
    while (n < 40 && resp_valid !== 1'b1) begin
      step(1);
      n++;
    end
    nvec++; if (n != 16) begin nerr++; $display("FAIL to_latency: got %0d cycles want 16", n); end
    nvec++; if ({resp_valid, resp_err, io_req, resp_rdata} !== {3'b110, 32'h0}) begin nerr++; $display("FAIL to_resp: got %b/%h want 110/0", {resp_valid, resp_err, io_req}, resp_rdata); end
    issue(32'h100, 32'h0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    step(2);
    nvec++; if ({resp_valid, resp_err} !== 2'b10) begin nerr++; $display("FAIL to_err_clear: got %b want 10", {resp_valid, resp_err}); end
  endtask

  task automatic test_reset_mid_store;
    issue(32'h80, 32'h0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    step(2);
    issue(32'h84, 32'h0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    step(2);
    issue(32'h81, 32'h55667788, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    nvec++; if (sram_we !== 4'b1110) begin nerr++; $display("FAIL rm_acc0: got %b want 1110", sram_we); end
    step(1);
    nvec++; if ({sram_we, sram_addr} !== {4'b0001, 10'h021}) begin nerr++; $display("FAIL rm_acc1: got %b/%h want 0001/021", sram_we, sram_addr); end
    rst = 1'b1;
    #1;
    nvec++; if (sram_en !== 1'b0) begin nerr++; $display("FAIL rm_gate: got %b want 0", sram_en); end
    step(1);
    rst = 1'b0;
    nvec++; if ({req_ready, resp_valid, io_req} !== 3'b100) begin nerr++; $display("FAIL rm_idle: got %b want 100", {req_ready, resp_valid, io_req}); end
    step(2);
    nvec++; if (resp_valid !== 1'b0) begin nerr++; $display("FAIL rm_no_resp: got %b want 0", resp_valid); end
    issue(32'h84, 32'h0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    step(2);
    nvec++; if (resp_rdata !== 32'h0) begin nerr++; $display("FAIL rm_word1: got %h want 0", resp_rdata); end
    issue(32'h80, 32'h0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    step(2);
    nvec++; if (resp_rdata !== 32'h66778800) begin nerr++; $display("FAIL rm_word0: got %h want 66778800", resp_rdata); end
  endtask

  initial begin
    req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_sz = '0;
    req_sx = 1'b0; req_r = 1'b0; req_w = 1'b0; req_io = 1'b0;
    io_ack = 1'b0; io_rdata = '0; rst = 1'b1;
    test_reset();
    test_aligned_word();
    test_byte_half();
    test_misaligned();
    test_wrap();
    test_ignored();
    test_io();
    test_io_timeout();
    test_reset_mid_store();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
